rect_query_arbiter: RTL and testbench
=====================================

# rect_query_arbiter

Round-robin arbiter that shares the single rectangle-sum query port of `integral_image` between two requesters, such as two `feature_calculator` lanes or a calculator plus a debug/readback client. It accepts one query at a time and drives a single-cycle `query_valid` to the integral image. It then routes the returned `rect_sum` back to the requester that owns the query. The block sits between the requesters and `integral_image`; the requesters never drive the query bus directly.

## Interface
- `COORD_WIDTH`, 8: width of each rectangle coordinate.
- `SUM_WIDTH`, 24: width of `rect_sum`.
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before an error response; must be ≥2. Used only with `RQA_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req0_valid`, `req1_valid` in 1: query request per requester.
- `req0_rect`, `req1_rect` in 4*COORD_WIDTH: packed coordinates {x1,y1,x2,y2}, with x1 in the MSBs.
- `req0_ready`, `req1_ready` out 1: accept strobe; the handshake completes when `valid` and `ready` are both high.
- `rsp0_sum`, `rsp1_sum` out SUM_WIDTH: returned sum.
- `rsp0_valid`, `rsp1_valid` out 1: one-cycle response pulse.
- `rsp0_err`, `rsp1_err` out 1: qualifies `rspN_valid`; high means a timeout occurred and the sum is 0.
- `query_x1`, `query_y1`, `query_x2`, `query_y2` out COORD_WIDTH: query bus to `integral_image`.
- `query_valid` out 1: one-cycle query strobe.
- `rect_sum` in SUM_WIDTH: sum from `integral_image`.
- `rect_sum_valid` in 1: sum strobe from `integral_image`.

## Operation
- States:
  - IDLE: waits for a request.
  - ISSUE: drives the query strobe.
  - WAIT: waits for the sum.
- Priority pointer `prio`, 1 bit, reset value 0.
  - In IDLE, the grant goes to requester `prio` if it is valid, otherwise to the other requester.
  - `prio` is set to the non-granted index on every accepted request.
- `reqN_ready` is combinational: (state==IDLE) && `reqN_valid` && grant==N.
  - At most one `ready` is high per cycle.
  - Requesters hold `valid` and `rect` stable until `ready` is seen.
- On accept, the arbiter latches the rect and the owner index.
  - Degenerate rect (x2<x1 or y2<y1): the query is not issued. The arbiter pulses `rspN_valid` with sum 0 and err 0 on the next cycle and stays in IDLE.
  - Otherwise: IDLE→ISSUE.
- ISSUE: `query_valid`=1 for exactly one cycle, with the latched coordinates on the `query_*` bus. Then ISSUE→WAIT.
- WAIT: on `rect_sum_valid`, register `rect_sum` into `rsp<owner>_sum` and pulse `rsp<owner>_valid` on the next cycle. Then WAIT→IDLE.
- `rspN_sum` holds its last value between pulses. `rspN_valid`/`rspN_err` are pulses.
- `rect_sum_valid` in IDLE or ISSUE is ignored; it is a stray strobe.
- Only one query is outstanding at any time; there is no pipelining across queries.
- Mid-operation reset: return to IDLE with `prio`=0 and every output at its reset value. An in-flight response is discarded.

## Timing
- Reset values: all `ready`, `rsp*_valid`, `rsp*_err` and `query_valid` are 0. `query_*` and `rsp*_sum` are 0.
- Cycle numbering for one query:
  - Cycle A: handshake accepted.
  - Cycle A+1: `query_valid`.
  - Cycle R (≥A+2): `rect_sum_valid`.
  - Cycle R+1: `rsp_valid`, with state already IDLE.
  - A new accept can occur in cycle R+1.
- Minimum request-to-response latency, with the integral image returning in the cycle after `query_valid`: 3 cycles.
- Degenerate rect: response at A+1. The next accept can occur at A+1.
- `query_*` holds the last issued coordinates outside ISSUE; only `query_valid` qualifies the bus.

## Configuration
- `RQA_TIMEOUT_EN` defined: a WAIT cycle counter runs, clearing on WAIT entry.
  - If `rect_sum_valid` is not seen by the TIMEOUT_CYCLES-th WAIT cycle, the arbiter pulses `rsp<owner>_valid` with `rsp<owner>_err`=1 and sum 0 on the next cycle, then returns to IDLE.
  - `rect_sum_valid` arriving in the same cycle as expiry wins and is returned normally with err 0.
  - TIMEOUT_CYCLES must exceed the worst-case `integral_image` latency. A late sum arriving during a later WAIT is indistinguishable from that query's own result.
- `RQA_TIMEOUT_EN` undefined: no counter; WAIT lasts until `rect_sum_valid`. `rsp*_err` is tied to 0.

## Test plan
- Single query on requester 0 with rect {2,3,5,7}; model returns 0x00ABCD two cycles after `query_valid`.
  - Expect `req0_ready` at cycle A and `query_valid` at A+1 with x1=2, y1=3, x2=5, y2=7.
  - Expect `rsp0_valid` with `rsp0_sum`=0x00ABCD; `rsp1_valid` never asserts.
- Both requesters valid continuously for 6 queries.
  - Expect grants in the order 0,1,0,1,0,1 and each response on the matching `rspN`.
- Requester 1 alone, back-to-back queries.
  - Expect each grant to go to requester 1 despite `prio`, with accepts spaced exactly at the R+1 cycle.
- Degenerate rect {5,0,4,9} on requester 0.
  - Expect no `query_valid`, and `rsp0_valid`=1 with sum 0 at A+1.
- Assert `rst` during WAIT, then drive `rect_sum_valid`.
  - Expect no `rsp` pulse and all outputs 0.
  - Expect the next request to start from `prio`=0.
- With `RQA_TIMEOUT_EN` and TIMEOUT_CYCLES=8, the model never responds.
  - Expect `rsp0_valid`=1, `rsp0_err`=1 and sum 0 after 8 WAIT cycles, then a return to IDLE and acceptance of the next request.

Source files
------------

// File: rtl/rect_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rect_query_arbiter
// Purpose  : Round-robin arbiter that shares the single rectangle-sum query
//            port of integral_image between two requesters. One query is
//            outstanding at a time; the returned sum is routed back to the
//            requester that owns the query.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            reqN_valid/rect/ready   - request handshake per requester (N=0,1)
//            rspN_sum/valid/err      - response per requester
//            query_x1..y2, query_valid - query bus to integral_image
//            rect_sum, rect_sum_valid  - sum returned by integral_image
// Options  : RQA_TIMEOUT_EN - when defined, a WAIT cycle counter returns an
//            error response after TIMEOUT_CYCLES cycles without a sum.
// Revision : 1.0 - initial release
// ============================================================================
module rect_query_arbiter #(
  parameter int COORD_WIDTH    = 8,
  parameter int SUM_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [4*COORD_WIDTH-1:0] req0_rect,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [4*COORD_WIDTH-1:0] req1_rect,
  output logic                     req1_ready,
  output logic [SUM_WIDTH-1:0]     rsp0_sum,
  output logic                     rsp0_valid,
  output logic                     rsp0_err,
  output logic [SUM_WIDTH-1:0]     rsp1_sum,
  output logic                     rsp1_valid,
  output logic                     rsp1_err,
  output logic [COORD_WIDTH-1:0]   query_x1,
  output logic [COORD_WIDTH-1:0]   query_y1,
  output logic [COORD_WIDTH-1:0]   query_x2,
  output logic [COORD_WIDTH-1:0]   query_y2,
  output logic                     query_valid,
  input  logic [SUM_WIDTH-1:0]     rect_sum,
  input  logic                     rect_sum_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                   state;
  logic                     prio;
  logic                     owner;
  logic                     grant;
  logic                     accept;
  logic [4*COORD_WIDTH-1:0] sel_rect;
  logic [COORD_WIDTH-1:0]   sel_x1, sel_y1, sel_x2, sel_y2;
  logic                     degenerate;
  logic                     rsp_fire;
  logic                     rsp_who;
  logic [SUM_WIDTH-1:0]     rsp_data;
  logic                     rsp_is_err;

  // Grant the priority requester if it asks, otherwise the other one.
  assign grant      = prio ? req1_valid : ~req0_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_rect   = grant ? req1_rect : req0_rect;
  assign sel_x1     = sel_rect[4*COORD_WIDTH-1 -: COORD_WIDTH];
  assign sel_y1     = sel_rect[3*COORD_WIDTH-1 -: COORD_WIDTH];
  assign sel_x2     = sel_rect[2*COORD_WIDTH-1 -: COORD_WIDTH];
  assign sel_y2     = sel_rect[COORD_WIDTH-1:0];
  assign degenerate = (sel_x2 < sel_x1) || (sel_y2 < sel_y1);

`ifdef RQA_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Counter value is the zero-based index of the current WAIT cycle.
  assign timeout_hit = (state == WAIT) && !rect_sum_valid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_is_err  = timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_err <= 1'b0;
      rsp1_err <= 1'b0;
    end else begin
      rsp0_err <= rsp_fire && !rsp_who && rsp_is_err;
      rsp1_err <= rsp_fire &&  rsp_who && rsp_is_err;
    end
  end
`else
  assign rsp_is_err = 1'b0;
  assign rsp0_err   = 1'b0;
  assign rsp1_err   = 1'b0;
`endif

  // Response source: an immediate zero for a degenerate rect, the returned
  // sum in WAIT, or a zero error response on timeout.
  always_comb begin
    rsp_fire = 1'b0;
    rsp_who  = owner;
    rsp_data = '0;
    if (state == IDLE) begin
      if (accept && degenerate) begin
        rsp_fire = 1'b1;
        rsp_who  = grant;
      end
    end else if (state == WAIT) begin
      if (rect_sum_valid) begin
        rsp_fire = 1'b1;
        rsp_data = rect_sum;
      end else if (rsp_is_err) begin
        rsp_fire = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      query_valid <= 1'b0;
      query_x1    <= '0;
      query_y1    <= '0;
      query_x2    <= '0;
      query_y2    <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_sum    <= '0;
      rsp1_sum    <= '0;
    end else begin
      query_valid <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;

      if (rsp_fire && !rsp_who) begin
        rsp0_valid <= 1'b1;
        rsp0_sum   <= rsp_data;
      end
      if (rsp_fire && rsp_who) begin
        rsp1_valid <= 1'b1;
        rsp1_sum   <= rsp_data;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            prio  <= ~grant;
            owner <= grant;
            if (!degenerate) begin
              // Bus is loaded here so it is valid alongside query_valid.
              query_x1    <= sel_x1;
              query_y1    <= sel_y1;
              query_x2    <= sel_x2;
              query_y2    <= sel_y2;
              query_valid <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (rsp_fire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rect_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_query_arbiter
// Purpose  : Randomized self-checking bench for rect_query_arbiter. Two
//            requesters and an integral_image responder are driven with
//            $urandom; a transaction-level reference model predicts every
//            output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_query_arbiter;

  localparam int CW   = 8;
  localparam int SW   = 24;
  localparam int NCYC = 1500;
`ifdef RQA_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 64;
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [4*CW-1:0] req0_rect, req1_rect;
  logic          req0_ready, req1_ready;
  logic [SW-1:0] rsp0_sum, rsp1_sum;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [CW-1:0] query_x1, query_y1, query_x2, query_y2;
  logic          query_valid;
  logic [SW-1:0] rect_sum;
  logic          rect_sum_valid;

  rect_query_arbiter #(
    .COORD_WIDTH   (CW),
    .SUM_WIDTH     (SW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_rect     (req0_rect),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_rect     (req1_rect),
    .req1_ready    (req1_ready),
    .rsp0_sum      (rsp0_sum),
    .rsp0_valid    (rsp0_valid),
    .rsp0_err      (rsp0_err),
    .rsp1_sum      (rsp1_sum),
    .rsp1_valid    (rsp1_valid),
    .rsp1_err      (rsp1_err),
    .query_x1      (query_x1),
    .query_y1      (query_y1),
    .query_x2      (query_x2),
    .query_y2      (query_y2),
    .query_valid   (query_valid),
    .rect_sum      (rect_sum),
    .rect_sum_valid(rect_sum_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
  endtask

  function automatic logic [4*CW-1:0] gen_rect();
    logic [CW-1:0] a, b, c, d;
    a = CW'($urandom); b = CW'($urandom); c = CW'($urandom); d = CW'($urandom);
    if ($urandom_range(0, 5) == 0) return {a, c, b, d};  // unordered, often degenerate
    return {(a < b) ? a : b, (c < d) ? c : d, (a < b) ? b : a, (c < d) ? d : c};
  endfunction

  // Reference model state: transaction view of the arbiter.
  bit              m_prio, m_busy, m_owner;
  int              m_issue_cyc, m_wait;
  logic [4*CW-1:0] m_query;
  logic [SW-1:0]   m_sum [2];
  bit              slot_v, slot_who, slot_err;
  logic [SW-1:0]   slot_sum;
  // Integral-image responder and requesters.
  int              img_due;
  logic [SW-1:0]   img_sum;
  bit              v [2];
  logic [4*CW-1:0] r [2];
  int              n_rsp, n_tmo, n_degen;

  initial begin
    bit idle, g, e_r0, e_r1, e_qv;
    int rate0, rate1;
    logic [4*CW-1:0] rr;

    m_prio = 0; m_busy = 0; m_owner = 0; m_issue_cyc = -10; m_wait = 0;
    m_query = '0; m_sum[0] = '0; m_sum[1] = '0;
    slot_v = 0; slot_who = 0; slot_err = 0; slot_sum = '0;
    img_due = -1; img_sum = '0; v[0] = 0; v[1] = 0; r[0] = '0; r[1] = '0;
    n_rsp = 0; n_tmo = 0; n_degen = 0;
    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_rect = '0; req1_rect = '0;
    rect_sum = '0; rect_sum_valid = 0;

    @(posedge clk); #1;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      // ---------------- drive phase ----------------
      if (cyc < 500)       begin rate0 = 40;  rate1 = 40;  end
      else if (cyc < 900)  begin rate0 = 100; rate1 = 100; end
      else if (cyc < 1200) begin rate0 = 0;   rate1 = 100; end
      else                 begin rate0 = 60;  rate1 = 20;  end

      rst = (cyc < 2) || ($urandom_range(0, 299) == 0) ||
            (m_busy && cyc > m_issue_cyc && $urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) begin
        if (rst) v[i] = 0;
        else if (!v[i] && $urandom_range(1, 100) <= ((i == 0) ? rate0 : rate1)) begin
          v[i] = 1;
          r[i] = gen_rect();
        end
      end
      req0_valid = v[0]; req0_rect = r[0];
      req1_valid = v[1]; req1_rect = r[1];
      rect_sum_valid = (cyc == img_due) || (!m_busy && $urandom_range(0, 15) == 0);
      rect_sum = (cyc == img_due) ? img_sum : SW'($urandom);

      @(negedge clk);
      // ---------------- check phase ----------------
      idle = !m_busy;
      g    = m_prio ? (v[1] ? 1'b1 : 1'b0) : (v[0] ? 1'b0 : 1'b1);
      e_r0 = idle && v[0] && !g;
      e_r1 = idle && v[1] && g;
      e_qv = m_busy && (cyc == m_issue_cyc);
      if (slot_v) m_sum[slot_who] = slot_sum;
      if (cyc >= 1) begin
        check_value("req0_ready", req0_ready, e_r0);
        check_value("req1_ready", req1_ready, e_r1);
        check_value("query_valid", query_valid, e_qv);
        check_value("query_bus", {query_x1, query_y1, query_x2, query_y2}, m_query);
        check_value("rsp0_valid", rsp0_valid, slot_v && !slot_who);
        check_value("rsp1_valid", rsp1_valid, slot_v && slot_who);
        check_value("rsp0_err", rsp0_err, slot_v && !slot_who && slot_err);
        check_value("rsp1_err", rsp1_err, slot_v && slot_who && slot_err);
        check_value("rsp0_sum", rsp0_sum, m_sum[0]);
        check_value("rsp1_sum", rsp1_sum, m_sum[1]);
      end

      // integral_image responder: latency 1..3 after query_valid, or silent
      if (query_valid) begin
        img_due = cyc + $urandom_range(1, 3);
        img_sum = SW'($urandom);
        if (TMO_EN && $urandom_range(0, 3) == 0) img_due = -1;
      end

      // ---------------- model advance ----------------
      slot_v = 0;
      if (rst) begin
        m_prio = 0; m_busy = 0; m_query = '0; m_sum[0] = '0; m_sum[1] = '0;
      end else if (idle) begin
        if (e_r0 || e_r1) begin
          rr = g ? r[1] : r[0];
          m_prio = !g;
          if (rr[15:8] < rr[31:24] || rr[7:0] < rr[23:16]) begin
            slot_v = 1; slot_who = g; slot_sum = '0; slot_err = 0;
            n_degen++;
          end else begin
            m_busy = 1; m_owner = g; m_issue_cyc = cyc + 1; m_query = rr; m_wait = 0;
          end
        end
      end else if (cyc > m_issue_cyc) begin
        m_wait++;
        if (rect_sum_valid) begin
          slot_v = 1; slot_who = m_owner; slot_sum = rect_sum; slot_err = 0;
          m_busy = 0; n_rsp++;
        end else if (TMO_EN && m_wait == TMO) begin
          slot_v = 1; slot_who = m_owner; slot_sum = '0; slot_err = 1;
          m_busy = 0; n_tmo++;
        end
      end
      // requesters release valid once the handshake completes
      if (req0_ready && v[0]) v[0] = 0;
      if (req1_ready && v[1]) v[1] = 0;

      @(posedge clk); #1;
    end

    check_value("responses_seen", n_rsp > 50, 1);
    check_value("degenerate_seen", n_degen > 5, 1);
    if (TMO_EN) check_value("timeouts_seen", n_tmo > 2, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
